axi_lite_sram_ctrl: RTL and testbench
=====================================

// Module: axi_lite_sram_ctrl
// PURPOSE
//  AXI4-Lite slave front end that feeds the single-port SRAM cell directly downstream of it.
//  Accepts one AXI transaction at a time: a write (AW+W) or a read (AR).
//  Drives the SRAM cell's chip-enable, write, masked-write and read strobes.
//  Captures the SRAM cell's asynchronous read data into a registered R channel.
// PARAMETERS
//  SRAM_DEPTH       512  number of 64-bit words in the downstream SRAM
//  DATA_WIDTH       64   AXI/SRAM data width; only 64 supported (8 byte lanes)
//  STRB_WIDTH       8    DATA_WIDTH/8; also the SRAM mask width
//  ADDR_WIDTH       32   AXI byte-address width
//  RAM_INDEX_WIDTH  9    SRAM word-index width; word index = addr[3 +: RAM_INDEX_WIDTH]
// PORTS
//  clk                 in   1        single clock; all logic is rising-edge
//  reset               in   1        synchronous, active-high reset
//  s_axi_awaddr        in   ADDR_W   write byte address
//  s_axi_awvalid       in   1        write address valid
//  s_axi_awready       out  1        write address ready
//  s_axi_wdata         in   DATA_W   write data
//  s_axi_wstrb         in   STRB_W   byte-lane strobes
//  s_axi_wvalid        in   1        write data valid
//  s_axi_wready        out  1        write data ready
//  s_axi_bresp         out  2        write response: 00 OKAY, 10 SLVERR
//  s_axi_bvalid        out  1        write response valid
//  s_axi_bready        in   1        write response ready
//  s_axi_araddr        in   ADDR_W   read byte address
//  s_axi_arvalid       in   1        read address valid
//  s_axi_arready       out  1        read address ready
//  s_axi_rdata         out  DATA_W   read data (registered)
//  s_axi_rresp         out  2        read response: 00 OKAY, 10 SLVERR
//  s_axi_rvalid        out  1        read data valid
//  s_axi_rready        in   1        read data ready
//  sram_chip_en_o      out  1        SRAM chip enable
//  sram_wr_en_o        out  1        SRAM write enable
//  sram_addr_o         out  RIW      SRAM word index
//  sram_wr_data_o      out  DATA_W   SRAM write data
//  sram_wr_mask_en_o   out  1        SRAM masked-write enable
//  sram_wr_mask_o      out  STRB_W   SRAM byte mask (= latched wstrb)
//  sram_rd_en_o        out  1        SRAM read enable
//  sram_rd_data_i      in   DATA_W   SRAM read data (combinational from SRAM)
// BEHAVIOUR
//  FSM states: IDLE, WR, WRESP, RD, RRESP. All outputs are registered.
//   - Reset value of every output is 0.
//   - Reset wins over any state: the FSM returns to IDLE and in-flight transactions are dropped.
//   - No SRAM strobe is driven in the cycle after reset deasserts.
//  IDLE, write path:
//   - If awvalid && wvalid, assert awready and wready together for 1 cycle.
//   - Latch the word index, wdata and wstrb; go to WR.
//   - AW without W, or W without AW, is not accepted; its ready stays 0.
//  IDLE, read path:
//   - Otherwise, if arvalid, assert arready for 1 cycle, latch the index and go to RD.
//   - On simultaneous write and read, the write wins; AR waits and is serviced after WRESP completes.
//  WR (1 cycle):
//   - Drive chip_en=1, wr_en=1, wr_mask_en=1 (always), wr_mask=wstrb, plus addr and data.
//   - Go to WRESP.
//   - wstrb=0 leaves the SRAM word unchanged and still returns OKAY.
//  WRESP: bvalid=1 and bresp held stable until bready; then go to IDLE.
//  RD (1 cycle):
//   - Drive chip_en=1, rd_en=1 and addr.
//   - Register sram_rd_data_i into rdata; go to RRESP.
//  RRESP: rvalid=1 with rdata/rresp held stable until rready; then go to IDLE.
//  Latency (handshake at cycle T): SRAM strobe in T+1; bvalid/rvalid first high in T+2.
//  Throughput: with ready held high, one transaction per 3 cycles.
//  Strobe rules:
//   - sram_wr_en_o and sram_rd_en_o are never high in the same cycle.
//   - sram_chip_en_o is high only in WR or RD.
//  Address: bits [2:0] are ignored; bits above the index are ignored unless the macro is set.
//  Read-after-write to the same address returns the newly written data.
// CONFIGURATION
//  SRAM_CTRL_ADDR_CHECK_EN defined:
//   - Word index >= SRAM_DEPTH, or any nonzero awaddr/araddr bit above the index field, is out of range.
//   - An out-of-range access drives no SRAM strobe in WR/RD.
//   - It returns resp=2'b10 (SLVERR); an out-of-range read returns rdata=0.
//  SRAM_CTRL_ADDR_CHECK_EN undefined:
//   - The index is truncated (wraps modulo 2^RAM_INDEX_WIDTH) and resp is always 2'b00.
// TESTING
//  1. Write 0x0123456789ABCDEF at 0x10 with strb 0xFF, then read 0x10:
//     bvalid at T+2 with OKAY; rdata=0x0123456789ABCDEF.
//  2. Prior word 0x0123456789ABCDEF; write 0xFFFF_FFFF_FFFF_FFFF at 0x10 with strb 0x0F; read back:
//     0x01234567FFFFFFFF.
//  3. Present AW+W and AR at the same cycle:
//     write handshakes first; arready rises only after the B handshake; read returns the new data.
//  4. Hold bready=0 for 5 cycles:
//     bvalid and bresp stay stable; no new AW/AR accepted; no SRAM strobes.
//  5. Assert reset while in RRESP:
//     next cycle all outputs are 0 and the state is IDLE; a subsequent read works.
//  6. Read 0x1000 (index 512):
//     with the macro: SLVERR, rdata=0, no chip_en; without it: index 0 is read, OKAY.

Source files
------------

// File: rtl/axi_lite_sram_ctrl.sv
// AXI4-Lite slave that sequences one write or read at a time into a single-port SRAM cell.
// Optional SRAM_CTRL_ADDR_CHECK_EN: out-of-range accesses return SLVERR with no SRAM strobe.
module axi_lite_sram_ctrl #(
  parameter int unsigned SRAM_DEPTH      = 512,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned RAM_INDEX_WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_WIDTH-1:0]      s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]      s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic                       sram_chip_en_o,
  output logic                       sram_wr_en_o,
  output logic [RAM_INDEX_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]      sram_wr_data_o,
  output logic                       sram_wr_mask_en_o,
  output logic [STRB_WIDTH-1:0]      sram_wr_mask_o,
  output logic                       sram_rd_en_o,
  input  logic [DATA_WIDTH-1:0]      sram_rd_data_i
);

  localparam int unsigned IDX_LSB = 3;
  localparam int unsigned IDX_TOP = IDX_LSB + RAM_INDEX_WIDTH;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RRESP} state_e;

  state_e                     state_q, state_d;
  logic                       awready_q, awready_d, arready_q, arready_d;
  logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d, wr_data_q, wr_data_d;
  logic                       chip_en_q, chip_en_d, wr_en_q, wr_en_d;
  logic                       mask_en_q, mask_en_d, rd_en_q, rd_en_d;
  logic [RAM_INDEX_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0]      mask_q, mask_d;
  logic                       err_q, err_d;

  logic [RAM_INDEX_WIDTH-1:0] aw_idx_c, ar_idx_c;
  logic                       aw_err_c, ar_err_c;
  logic                       pick_c, pick_wr_c, pick_rd_c;
  logic                       addr_unused_c;

  assign aw_idx_c = s_axi_awaddr[IDX_LSB +: RAM_INDEX_WIDTH];
  assign ar_idx_c = s_axi_araddr[IDX_LSB +: RAM_INDEX_WIDTH];

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  assign aw_err_c = (32'(aw_idx_c) >= SRAM_DEPTH) || (|s_axi_awaddr[ADDR_WIDTH-1:IDX_TOP]);
  assign ar_err_c = (32'(ar_idx_c) >= SRAM_DEPTH) || (|s_axi_araddr[ADDR_WIDTH-1:IDX_TOP]);
`else
  assign aw_err_c = 1'b0;
  assign ar_err_c = 1'b0;
`endif

  assign addr_unused_c = ^{s_axi_awaddr[IDX_LSB-1:0], s_axi_araddr[IDX_LSB-1:0],
                           s_axi_awaddr[ADDR_WIDTH-1:IDX_TOP], s_axi_araddr[ADDR_WIDTH-1:IDX_TOP],
                           SRAM_DEPTH};

  // A new request may be chosen when idle, or in the cycle the current response completes.
  assign pick_c    = ((state_q == S_IDLE) && !awready_q && !arready_q) ||
                     ((state_q == S_WRESP) && s_axi_bready) ||
                     ((state_q == S_RRESP) && s_axi_rready);
  assign pick_wr_c = pick_c && s_axi_awvalid && s_axi_wvalid;
  assign pick_rd_c = pick_c && !(s_axi_awvalid && s_axi_wvalid) && s_axi_arvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      wr_data_q <= '0;
      chip_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      mask_en_q <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      wr_data_q <= wr_data_d;
      chip_en_q <= chip_en_d;
      wr_en_q   <= wr_en_d;
      mask_en_q <= mask_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
    end
  end

  // Next state: IDLE leaves only in the cycle a registered ready completes the handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (awready_q)      state_d = S_WR;
        else if (arready_q) state_d = S_RD;
      end
      S_WR:    state_d = S_WRESP;
      S_RD:    state_d = S_RRESP;
      S_WRESP: if (s_axi_bready) state_d = S_IDLE;
      S_RRESP: if (s_axi_rready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    awready_d = pick_wr_c;
    arready_d = pick_rd_c;
    chip_en_d = 1'b0;
    wr_en_d   = 1'b0;
    mask_en_d = 1'b0;
    rd_en_d   = 1'b0;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (awready_q) begin
          err_d     = aw_err_c;
          addr_d    = aw_idx_c;
          wr_data_d = s_axi_wdata;
          mask_d    = s_axi_wstrb;
          chip_en_d = !aw_err_c;
          wr_en_d   = !aw_err_c;
          mask_en_d = !aw_err_c;
        end else if (arready_q) begin
          err_d     = ar_err_c;
          addr_d    = ar_idx_c;
          chip_en_d = !ar_err_c;
          rd_en_d   = !ar_err_c;
        end
      end
      S_WR: begin
        bvalid_d = 1'b1;
        bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      S_RD: begin
        rvalid_d = 1'b1;
        rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
        rdata_d  = err_q ? '0 : sram_rd_data_i;
      end
      S_WRESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
        end
      end
      S_RRESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          rresp_d  = RESP_OKAY;
        end
      end
      default: ;
    endcase
  end

  assign s_axi_awready     = awready_q;
  assign s_axi_wready      = awready_q;
  assign s_axi_arready     = arready_q;
  assign s_axi_bvalid      = bvalid_q;
  assign s_axi_bresp       = bresp_q;
  assign s_axi_rvalid      = rvalid_q;
  assign s_axi_rresp       = rresp_q;
  assign s_axi_rdata       = rdata_q;
  assign sram_chip_en_o    = chip_en_q;
  assign sram_wr_en_o      = wr_en_q;
  assign sram_addr_o       = addr_q;
  assign sram_wr_data_o    = wr_data_q;
  assign sram_wr_mask_en_o = mask_en_q;
  assign sram_wr_mask_o    = mask_q;
  assign sram_rd_en_o      = rd_en_q;

endmodule

// File: tb/tb_axi_lite_sram_ctrl.sv
// Directed bench for axi_lite_sram_ctrl with a behavioural byte-masked SRAM cell attached.
module tb_axi_lite_sram_ctrl;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata, wr_data, rd_data;
  logic [7:0]  wstrb, mask;
  logic [1:0]  bresp, rresp;
  logic        chip_en, wr_en, mask_en, rd_en;
  logic [8:0]  addr_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [512] = '{default: 64'h0};

  always #5 clk = ~clk;

  axi_lite_sram_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .s_axi_awaddr      (awaddr),
    .s_axi_awvalid     (awvalid),
    .s_axi_awready     (awready),
    .s_axi_wdata       (wdata),
    .s_axi_wstrb       (wstrb),
    .s_axi_wvalid      (wvalid),
    .s_axi_wready      (wready),
    .s_axi_bresp       (bresp),
    .s_axi_bvalid      (bvalid),
    .s_axi_bready      (bready),
    .s_axi_araddr      (araddr),
    .s_axi_arvalid     (arvalid),
    .s_axi_arready     (arready),
    .s_axi_rdata       (rdata),
    .s_axi_rresp       (rresp),
    .s_axi_rvalid      (rvalid),
    .s_axi_rready      (rready),
    .sram_chip_en_o    (chip_en),
    .sram_wr_en_o      (wr_en),
    .sram_addr_o       (addr_o),
    .sram_wr_data_o    (wr_data),
    .sram_wr_mask_en_o (mask_en),
    .sram_wr_mask_o    (mask),
    .sram_rd_en_o      (rd_en),
    .sram_rd_data_i    (rd_data)
  );

  // SRAM cell: byte-masked synchronous write, asynchronous read only while enabled.
  always @(posedge clk) begin
    if (chip_en && wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (!mask_en || mask[b]) mem[addr_o][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end
  assign rd_data = (chip_en && rd_en) ? mem[addr_o] : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({awready, wready, arready, bvalid, bresp, rvalid, rresp,
                              chip_en, wr_en, mask_en, rd_en, mask, addr_o}), 64'h0);
    chk({tag, "_rdata"}, rdata, 64'h0);
    chk({tag, "_wr_data"}, wr_data, 64'h0);
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [8:0] idx, input logic [63:0] d,
                           input logic [7:0] s, input logic [1:0] resp, input logic strobe,
                           input int bhold);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = (bhold == 0);
    tick();
    chk("wr_awready", awready, 1);
    chk("wr_wready", wready, 1);
    chk("wr_arready_blocked", arready, 0);
    chk("wr_no_early_strobe", chip_en, 0);
    tick();
    chk("wr_awready_drop", awready, 0);
    chk("wr_chip_en", chip_en, strobe);
    chk("wr_wr_en", wr_en, strobe);
    chk("wr_mask_en", mask_en, strobe);
    chk("wr_rd_en_low", rd_en, 0);
    if (strobe) begin
      chk("wr_addr", addr_o, idx);
      chk("wr_data", wr_data, d);
      chk("wr_mask", mask, s);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("wr_bvalid", bvalid, 1);
    chk("wr_bresp", bresp, resp);
    for (int i = 0; i < bhold; i++) begin
      tick();
      chk("hold_bvalid", bvalid, 1);
      chk("hold_bresp", bresp, resp);
      chk("hold_no_strobe", chip_en, 0);
      chk("hold_no_accept", 64'({awready, arready}), 0);
    end
    bready = 1'b1;
    tick();
    chk("wr_bvalid_drop", bvalid, 0);
    chk("wr_idle_no_strobe", chip_en, 0);
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [8:0] idx, input logic [63:0] d,
                          input logic [1:0] resp, input logic strobe, input logic queued);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    if (!queued) tick();
    chk("rd_arready", arready, 1);
    tick();
    chk("rd_arready_drop", arready, 0);
    chk("rd_chip_en", chip_en, strobe);
    chk("rd_rd_en", rd_en, strobe);
    chk("rd_wr_en_low", wr_en, 0);
    if (strobe) chk("rd_addr", addr_o, idx);
    arvalid = 1'b0;
    tick();
    chk("rd_rvalid", rvalid, 1);
    chk("rd_rdata", rdata, d);
    chk("rd_rresp", rresp, resp);
    tick();
    chk("rd_rvalid_drop", rvalid, 0);
    chk("rd_idle_no_strobe", chip_en, 0);
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk("post_reset_no_strobe", 64'({chip_en, wr_en, rd_en}), 0);

    // Full write then read back
    write_txn(32'h10, 9'd2, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 1'b1, 0);
    read_txn(32'h10, 9'd2, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 1'b0);

    // Partial strobe, then an all-zero strobe that must leave the word alone
    write_txn(32'h10, 9'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b00, 1'b1, 0);
    read_txn(32'h10, 9'd2, 64'h0123_4567_FFFF_FFFF, 2'b00, 1'b1, 1'b0);
    write_txn(32'h10, 9'd2, 64'h0, 8'h00, 2'b00, 1'b1, 0);
    read_txn(32'h10, 9'd2, 64'h0123_4567_FFFF_FFFF, 2'b00, 1'b1, 1'b0);

    // Simultaneous AW+W and AR: write first, queued read sees the new data
    araddr = 32'h10; arvalid = 1'b1;
    write_txn(32'h10, 9'd2, 64'hCAFE_BABE_DEAD_BEEF, 8'hFF, 2'b00, 1'b1, 0);
    read_txn(32'h10, 9'd2, 64'hCAFE_BABE_DEAD_BEEF, 2'b00, 1'b1, 1'b1);

    // Back-pressured B with an AR waiting behind it
    araddr = 32'h18; arvalid = 1'b1;
    write_txn(32'h18, 9'd3, 64'h0011_2233_4455_6677, 8'hFF, 2'b00, 1'b1, 5);
    read_txn(32'h18, 9'd3, 64'h0011_2233_4455_6677, 2'b00, 1'b1, 1'b1);

    // Low address bits are ignored
    read_txn(32'h1F, 9'd3, 64'h0011_2233_4455_6677, 2'b00, 1'b1, 1'b0);

    // Reset while a read response is pending
    araddr = 32'h18; arvalid = 1'b1; rready = 1'b0;
    tick();
    chk("rst_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    tick();
    chk("rst_rvalid_pending", rvalid, 1);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0; rready = 1'b1;
    tick();
    chk("after_reset_quiet", 64'({rvalid, arready, awready, chip_en}), 0);
    read_txn(32'h18, 9'd3, 64'h0011_2233_4455_6677, 2'b00, 1'b1, 1'b0);

    // Index boundaries and addresses above the index field
    write_txn(32'h0, 9'd0, 64'h1111_2222_3333_4444, 8'hFF, 2'b00, 1'b1, 0);
    write_txn(32'hFF8, 9'd511, 64'h5555_6666_7777_8888, 8'hFF, 2'b00, 1'b1, 0);
    read_txn(32'hFF8, 9'd511, 64'h5555_6666_7777_8888, 2'b00, 1'b1, 1'b0);
    read_txn(32'h1000, 9'd0, ACHK ? 64'h0 : 64'h1111_2222_3333_4444,
             ACHK ? 2'b10 : 2'b00, !ACHK, 1'b0);
    write_txn(32'h1008, 9'd1, 64'h7777_7777_7777_7777, 8'hFF, ACHK ? 2'b10 : 2'b00, !ACHK, 0);
    read_txn(32'h8, 9'd1, ACHK ? 64'h0 : 64'h7777_7777_7777_7777, 2'b00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
